// File: rtl/alu_writeback_stage.sv
// Purpose: execute/writeback stage; registers ALU result+status, commits to an 8-entry RF and {C,V,Z,N} flags.
// Latency: ALU output -> wb_* one cycle; -> RF/flags two cycles; read ports bypass the pending entry.
// Backpressure: stall freezes the stage (in_ready = ~stall); flush kills pending and incoming work.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid, in_ready             upstream handshake (in_ready = ~stall)
//   alu_f, alu_cout, alu_v, alu_z  ALU result and status
//   dest, we, fe                   destination register, RF write enable, flag update enable
//   stall, flush                   pipeline control (flush overrides stall)
//   rd_addr_a/b, rd_data_a/b       bypassed combinational read ports
//   flags, cin_fwd                 committed {C,V,Z,N}; carry forwarded to next ALU Cin
//   wb_valid, wb_dest, wb_data     pending (captured, uncommitted) entry
//   retired                        committed-instruction counter (wraps)
module alu_writeback_stage #(
    parameter int N  = 4,
    parameter int AW = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  alu_f,
    input  logic          alu_cout,
    input  logic          alu_v,
    input  logic          alu_z,
    input  logic [AW-1:0] dest,
    input  logic          we,
    input  logic          fe,
    input  logic          stall,
    input  logic          flush,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [N-1:0]  rd_data_a,
    output logic [N-1:0]  rd_data_b,
    output logic [3:0]    flags,
    output logic          cin_fwd,
    output logic          wb_valid,
    output logic [AW-1:0] wb_dest,
    output logic [N-1:0]  wb_data,
    output logic [CW-1:0] retired
);

    localparam int DEPTH = 2 ** AW;

    // Stage register
    logic          s_valid;
    logic [N-1:0]  s_f;
    logic [AW-1:0] s_dest;
    logic          s_we;
    logic          s_fe;
    logic          s_c;
    logic          s_v;
    logic          s_z;
    logic          s_n;

    // Architectural state
    logic [N-1:0]  rf [DEPTH];
    logic [3:0]    flags_q;
    logic [CW-1:0] retired_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid   <= 1'b0;
            s_f       <= '0;
            s_dest    <= '0;
            s_we      <= 1'b0;
            s_fe      <= 1'b0;
            s_c       <= 1'b0;
            s_v       <= 1'b0;
            s_z       <= 1'b0;
            s_n       <= 1'b0;
            flags_q   <= '0;
            retired_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
        end else if (flush) begin
            // Pending entry is discarded without commit; incoming one is dropped.
            s_valid <= 1'b0;
        end else if (!stall) begin
            // Commit of the pending entry and capture of the next share this edge.
            if (s_valid) begin
                if (s_we && (s_dest != '0)) begin
                    rf[s_dest] <= s_f;
                end
                if (s_fe) begin
                    flags_q <= {s_c, s_v, s_z, s_n};
                end
                retired_q <= retired_q + CW'(1);
            end
            s_valid <= in_valid;
            if (in_valid) begin
                s_f    <= alu_f;
                s_dest <= dest;
                s_we   <= we;
                s_fe   <= fe;
                s_c    <= alu_cout;
                s_v    <= alu_v;
                s_z    <= alu_z;
                s_n    <= alu_f[N-1];
            end
        end
    end

    // r0 is hardwired to zero and never bypassed; otherwise the pending
    // entry wins over the RF so a dependent op sees the newest result.
    assign rd_data_a = (rd_addr_a == '0) ? '0 :
                       (s_valid && s_we && (s_dest == rd_addr_a)) ? s_f : rf[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 :
                       (s_valid && s_we && (s_dest == rd_addr_b)) ? s_f : rf[rd_addr_b];

    // Carry is forwarded from the pending entry so add-with-carry chains issue back-to-back.
    assign cin_fwd  = (s_valid && s_fe) ? s_c : flags_q[3];

    assign in_ready = ~stall;
    assign flags    = flags_q;
    assign wb_valid = s_valid;
    assign wb_dest  = s_dest;
    assign wb_data  = s_f;
    assign retired  = retired_q;

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Execute/writeback pipeline stage sitting directly downstream of the n-bit ALU in the 3-stage processor.
- Captures the ALU result and status (F, Cout, V, Z) into a pipeline register, then commits it one cycle later to an 8-entry register file and a 4-bit flag register (C, V, Z, N).
- Provides bypassed read ports and a forwarded carry, so the upstream operand stage can issue back-to-back dependent ops (including add-with-carry) without stalls.
- Keeps a retired-instruction counter.

Parameters:
- N, 4, datapath width; matches the ALU width.
- AW, 3, register address width; register file depth is 2**AW.
- CW, 16, retired-instruction counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU output this cycle belongs to a live instruction.
- in_ready  out  1  stage accepts input; equals ~stall.
- alu_f  in  N  ALU result (Fout).
- alu_cout  in  1  ALU carry out.
- alu_v  in  1  ALU overflow.
- alu_z  in  1  ALU zero.
- dest  in  AW  destination register.
- we  in  1  instruction writes dest.
- fe  in  1  instruction updates flags.
- stall  in  1  freeze stage; no capture, no commit.
- flush  in  1  kill the pending and incoming instruction.
- rd_addr_a  in  AW  read port A address.
- rd_addr_b  in  AW  read port B address.
- rd_data_a  out  N  read port A data, bypassed.
- rd_data_b  out  N  read port B data, bypassed.
- flags  out  4  committed {C,V,Z,N}.
- cin_fwd  out  1  forwarded carry for next ALU Cin.
- wb_valid  out  1  pending (captured, uncommitted) entry present.
- wb_dest  out  AW  pending destination.
- wb_data  out  N  pending result.
- retired  out  CW  committed-instruction count.

Behaviour:
- Reset (async, immediate): all RF entries 0, flags 0, wb_valid 0, wb_dest 0, wb_data 0, retired 0. The stage register also clears internal copies of we, fe and the four status bits.
- Stage register S holds: valid, f, dest, we, fe, c, v, z, n. The n bit is alu_f[N-1] sampled at capture.
- Each clock edge is resolved in priority order: rst > flush > stall > normal.
- flush:
  - S.valid <= 0; the incoming instruction is dropped; the pending entry is NOT committed.
  - flush overrides stall.
- stall (no flush):
  - S, RF, flags and retired all hold.
  - in_ready = 0; upstream must hold its outputs.
- Normal edge:
  - Commit: if S.valid, write RF[S.dest] <= S.f when S.we and S.dest != 0.
  - Commit: if S.valid and S.fe, flags <= {S.c, S.v, S.z, S.n}.
  - Commit: if S.valid, retired <= retired + 1, wrapping modulo 2**CW.
  - Capture: S.valid <= in_valid, and S loads all inputs in the same edge. With in_valid = 0, only valid clears; data fields may hold.
- Latency:
  - ALU output to wb_* visibility: 1 cycle.
  - To RF/flags visibility: 2 cycles.
  - Bypass makes the result readable combinationally from the cycle after capture.
- Register 0:
  - Always reads 0; writes are ignored.
  - Never bypassed.
- Read ports (combinational), per port:
  - addr == 0 gives 0.
  - Otherwise, if S.valid & S.we & S.dest == addr, gives S.f.
  - Otherwise gives RF[addr].
- Same-cycle write and read of the same address returns the S value, i.e. the newest result.
- cin_fwd = S.c if S.valid & S.fe, else flags.C.
- The flags output shows committed state only; it is not bypassed.
- Back-to-back valid inputs: commit of entry k and capture of entry k+1 occur on the same edge. Full throughput is one instruction per cycle.
- A stall asserted while S.valid = 0 freezes an empty stage. No spurious commit occurs on release.
- Reset mid-operation discards the pending entry; nothing is committed.

Test Plan:
- Reset with rst asserted mid-cycle (async) → outputs clear immediately: flags = 0, retired = 0, both read ports return 0 for every address.
- Write r3: in_valid = 1, alu_f = 4'hA, dest = 3, we = 1, fe = 0 → next cycle wb_valid = 1, rd_data_a(3) = A via bypass. The cycle after, RF[3] = A, wb_valid = 0, retired = 1.
- Flags and forwarded carry: alu_f = 4'h0, cout = 1, v = 1, z = 1, fe = 1 → cin_fwd = 1 one cycle later; flags = 4'b1110 two cycles later.
- Back-to-back to the same register: r5 <= 1, then r5 <= 2 on consecutive cycles → port B reads 1 then 2 on consecutive cycles; final RF[5] = 2; retired increments by 2.
- Stall and flush: capture r2 <= 7, then stall for 3 cycles → RF[2] unchanged and bypass still returns 7. Then assert flush → RF[2] stays 0, retired unchanged.
- r0 write and counter wrap:
  - dest = 0, we = 1, alu_f = F → rd_data_a(0) = 0 always.
  - With CW forced to 4, after 16 commits → retired = 0.
